// File: rtl/spart_tx_fifo_if.sv
// Handshake bundle between the MMU store path, the TX FIFO and the SPART transmitter.
// The master side drives writes and the transmitter ready; the slave side is the FIFO.
interface spart_tx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int CW     = $clog2(DEPTH) + 1
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              overflow;
    logic              clr_overflow;

    modport master (
        output wr_en, wr_data, tx_ready, clr_overflow,
        input  full, empty, count, tx_valid, tx_data, overflow
    );

    modport slave (
        input  wr_en, wr_data, tx_ready, clr_overflow,
        output full, empty, count, tx_valid, tx_data, overflow
    );
endinterface

// File: rtl/spart_tx_fifo.sv
// Byte FIFO decoupling CPU stores to the SPART TX address from the transmitter baud rate.
// Status flags come only from the registered count, so full has no path from wr_en/tx_ready.
module spart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    spart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              full;
    logic              empty;
    logic              push_req;
    logic              pop;
    logic              push;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_req = bus.wr_en;
    assign pop      = !empty && bus.tx_ready;
    // A write on a full FIFO still lands when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (push_req && !push)     overflow <= 1'b1;
            else if (bus.clr_overflow) overflow <= 1'b0;
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = mem[rd_ptr];
    assign bus.overflow = overflow;
endmodule

// File: doc/spart_tx_fifo.md
Name: spart_tx_fifo

Overview:
- Byte FIFO between the MMU's memory-mapped SPART transmit path and the SPART transmitter.
- When the CPU stores to 0x00a00000, the MMU presents the byte with a write strobe. This block buffers the byte and drives its `full` output back to the MMU's spart_tx_full input.
- The transmitter drains bytes with a valid/ready handshake, which decouples CPU stores from the baud rate.
- Also provides an occupancy count and a sticky overflow flag for debug readback.

Parameters:
- DEPTH, 16, number of entries; must be a power of 2 and ≥ 2.
- DATA_W, 8, byte width.
- CW, log2(DEPTH)+1, width of `count`.

Ports:
- clk  input  1  system clock (100 MHz domain); all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write strobe from the MMU; one byte per cycle while high.
- wr_data  input  DATA_W  byte to enqueue.
- full  output  1  count == DEPTH; connects to the MMU's spart_tx_full.
- empty  output  1  count == 0.
- count  output  CW  current occupancy, 0..DEPTH.
- tx_valid  output  1  head byte is available to the transmitter.
- tx_data  output  DATA_W  head byte.
- tx_ready  input  1  transmitter accepts the head byte this cycle.
- overflow  output  1  sticky flag: a write was dropped.
- clr_overflow  input  1  synchronous clear of `overflow`.

Behaviour:
- Reset (rst = 0, asynchronous):
  - wr_ptr, rd_ptr, count = 0.
  - full = 0, empty = 1, tx_valid = 0, overflow = 0.
  - All storage entries = 0, so tx_data = 0.
  - Reset asserted mid-transfer discards all queued data immediately. No handshake completes in that cycle.
- Storage and pointers:
  - Storage is a DEPTH × DATA_W register array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Outputs:
  - tx_data = mem[rd_ptr], read combinationally.
  - tx_valid = !empty.
  - full, empty and tx_valid are derived from the registered count and have no combinational path from wr_en or tx_ready.
- Events per cycle:
  - push_req = wr_en.
  - pop = tx_valid & tx_ready.
  - push = push_req & (!full | pop).
- Push:
  - mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1.
- Pop:
  - rd_ptr <= rd_ptr + 1.
  - The transmitter samples tx_data in the same cycle it asserts tx_ready.
- Count update:
  - push & !pop: count + 1.
  - pop & !push: count - 1.
  - both or neither: unchanged.
- Latency:
  - A byte written at edge N into an empty FIFO gives tx_valid = 1 and tx_data = that byte after edge N.
  - It can be popped at edge N+1 at the earliest.
  - There is no fall-through in the same cycle.
- Boundary cases:
  - Full with simultaneous write and pop: the write is accepted, count stays DEPTH, full stays 1.
  - Full with write and no pop: the byte is dropped, pointers and count are unchanged, overflow <= 1.
  - Empty: tx_ready is ignored; rd_ptr and count never underflow.
  - Empty with simultaneous write and tx_ready: no pop; after the edge, count = 1.
- Overflow flag:
  - clr_overflow clears it.
  - If clr_overflow coincides with a new dropped write, set wins: overflow = 1.
- Handshake stability: while tx_valid = 1 and tx_ready = 0, tx_data and tx_valid hold stable. Pushes never alter the head entry, because wr_ptr ≠ rd_ptr whenever count > 0 and not full.
- No X propagation: wr_data is ignored when wr_en = 0 or when the write is dropped.

Test Plan:
- Reset and latency: assert rst = 0 mid-run with 5 bytes queued, then release → count = 0, empty = 1, tx_valid = 0, tx_data = 0x00. Next, write 0xA5 with tx_ready = 0 → one cycle later tx_valid = 1, tx_data = 0xA5, count = 1.
- Order and wrap: write 0x00..0x17 (24 bytes) with tx_ready toggling 1-of-2 cycles → transmitter receives 0x00..0x17 in order with no loss. Pointers wrap past 15; empty = 1 at the end.
- Fill and overflow: with tx_ready = 0, write 17 bytes 0x10..0x20 → full = 1 after the 16th write, count = 16. The 17th (0x20) is dropped and overflow = 1. Draining yields 0x10..0x1F.
- Write on full with pop: FIFO full holding 0x30..0x3F; in one cycle wr_en = 1 (0x40) and tx_ready = 1 → 0x30 is popped, count stays 16, overflow stays 0. The final drained byte is 0x40.
- Simultaneous on empty and on one entry:
  - Empty, wr_en = 1 (0x55), tx_ready = 1 → no pop; count = 1.
  - Next cycle, wr_en = 1 (0x66), tx_ready = 1 → 0x55 popped, count = 1, tx_data = 0x66.
- Overflow clear priority: overflow = 1 and FIFO full; clr_overflow = 1 alone → overflow = 0. clr_overflow = 1 together with a dropped write → overflow = 1.
